// File: rtl/prog_loader.sv
// SAP-1 program loader: streams an image into RAM, checks the trailing
// checksum, then hands RAM addressing to the CPU and releases its reset.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [DATA_W-1:0] byte_data_i,
  output logic              byte_ready_o,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  output logic              cpu_rstn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } state_t;

  // One extra count bit lets DEPTH == 2**ADDR_W be counted without wrapping.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                we_q, we_d;
  logic                hs;

  // Status outputs are pure decodes of the registered state.
  assign byte_ready_o = (state_q == LOAD) || (state_q == CHECK);
  assign busy_o       = (state_q == LOAD) || (state_q == CHECK);
  assign done_o       = (state_q == RUN);
  assign cpu_rstn_o   = (state_q == RUN);
  assign err_o        = (state_q == ERR);

  assign hs = byte_valid_i & byte_ready_o;

  // Only combinational input-to-output path: CPU owns the address in RUN.
  assign ram_addr_o  = (state_q == RUN) ? cpu_addr_i : wr_addr_q;
  assign ram_wdata_o = wr_data_q;
  assign ram_we_o    = we_q;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    we_d      = 1'b0;
    case (state_q)
      IDLE, RUN, ERR: begin
        if (start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      LOAD: begin
        if (hs) begin
          wr_data_d = byte_data_i;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          we_d      = 1'b1;
          sum_d     = sum_q + byte_data_i;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        // The checksum byte is compared only; it is never written to RAM.
        if (hs) begin
          state_d = (byte_data_i == sum_q) ? RUN : ERR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      we_q      <= we_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued by the
// stimulus and popped by a monitor on every observed write strobe.
module tb_prog_loader;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       byte_valid_i = 1'b0;
  logic [7:0] byte_data_i = '0;
  logic       byte_ready_o;
  logic [3:0] cpu_addr_i = '0;
  logic [3:0] ram_addr_o;
  logic [7:0] ram_wdata_o;
  logic       ram_we_o;
  logic       cpu_rstn_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int passed = 0;
  int total  = 0;
  logic [11:0] exp_q[$];

  prog_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready_o), .cpu_addr_i(cpu_addr_i),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o),
    .cpu_rstn_o(cpu_rstn_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk_i) begin
    if (ram_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'h0, ram_addr_o, ram_wdata_o}, 32'hFFFFFFFF);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("ram_write", {20'h0, ram_addr_o, ram_wdata_o}, {20'h0, e});
        $display("write addr=%0h data=%02h", ram_addr_o, ram_wdata_o);
      end
    end
  end

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Present one byte and hold it until the handshake edge has passed.
  task automatic send(input logic [7:0] b, input bit is_data, input logic [3:0] addr);
    bit ok = 0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk_i);
      if (byte_ready_o) begin
        @(posedge clk_i); #1;
        ok = 1;
        if (is_data) exp_q.push_back({addr, b});
      end
    end
    if (!ok) check("handshake_timeout", 0, 1);
    byte_valid_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic load_image(input logic [7:0] base, input logic [7:0] csum, input bit gapped);
    for (int i = 0; i < 16; i++) begin
      send(base + 8'(i), 1'b1, 4'(i));
      if (gapped) idle_cycle();
    end
    send(csum, 1'b0, 4'h0);
    $display("image base=%02h csum=%02h sent", base, csum);
  endtask

  initial begin
    // Reset values while held in reset
    #12;
    check("rst_ready", byte_ready_o, 0);
    check("rst_we", ram_we_o, 0);
    check("rst_cpu_rstn", cpu_rstn_o, 0);
    check("rst_flags", {busy_o, done_o, err_o}, 0);
    check("rst_addr_data", {ram_addr_o, ram_wdata_o}, 0);
    rst_i = 1'b0;
    idle_cycle();
    check("idle_ready", byte_ready_o, 0);
    check("idle_busy", busy_o, 0);

    // Good image
    do_start();
    check("load_ready", byte_ready_o, 1);
    check("load_busy", busy_o, 1);
    load_image(8'h00, 8'h78, 1'b0);
    check("good_cpu_rstn", cpu_rstn_o, 1);
    check("good_done", done_o, 1);
    check("good_busy", busy_o, 0);
    check("good_err", err_o, 0);

    // Async reset between edges clears outputs immediately
    @(negedge clk_i); #2;
    rst_i = 1'b1; #1;
    check("async_rst_cpu_rstn", cpu_rstn_o, 0);
    check("async_rst_done", done_o, 0);
    #1 rst_i = 1'b0;
    idle_cycle();

    // Bad checksum, then recovery with a good image
    do_start();
    load_image(8'h00, 8'h77, 1'b0);
    check("bad_err", err_o, 1);
    check("bad_cpu_rstn", cpu_rstn_o, 0);
    check("bad_ready", byte_ready_o, 0);
    do_start();
    check("restart_err_clear", err_o, 0);
    load_image(8'h00, 8'h78, 1'b0);
    check("recover_done", done_o, 1);
    check("recover_err", err_o, 0);

    // Gapped stream, sum wraps: 16 * 0xFF mod 256 = 0xF0
    do_start();
    for (int i = 0; i < 16; i++) begin
      send(8'hFF, 1'b1, 4'(i));
      idle_cycle();
    end
    send(8'hF0, 1'b0, 4'h0);
    check("gapped_done", done_o, 1);

    // Reset after five bytes, then restart at address 0
    do_start();
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 1'b1, 4'(i));
    @(negedge clk_i); #2;
    rst_i = 1'b1; #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_cpu_rstn", cpu_rstn_o, 0);
    #1 rst_i = 1'b0;
    idle_cycle();
    check("midrst_ready", byte_ready_o, 0);
    do_start();
    load_image(8'h10, 8'h78, 1'b0);
    check("midrst_recover_done", done_o, 1);

    // RUN arbitration: CPU drives the address, stream is refused
    cpu_addr_i = 4'h9; #1;
    check("run_addr_mux", ram_addr_o, 4'h9);
    check("run_we", ram_we_o, 0);
    byte_valid_i = 1'b1; byte_data_i = 8'hAA;
    idle_cycle(); idle_cycle();
    check("run_ready", byte_ready_o, 0);
    byte_valid_i = 1'b0;

    // Restart from RUN: CPU held, address back to last write address
    do_start();
    check("rerun_cpu_rstn", cpu_rstn_o, 0);
    check("rerun_busy", busy_o, 1);
    check("rerun_addr", ram_addr_o, 4'hF);

    // start pulsed mid-load has no effect
    for (int i = 0; i < 3; i++) send(8'h20 + 8'(i), 1'b1, 4'(i));
    start_i = 1'b1;
    idle_cycle();
    start_i = 1'b0;
    check("load_start_ignored", busy_o, 1);
    for (int i = 3; i < 16; i++) send(8'h20 + 8'(i), 1'b1, 4'(i));
    send(8'h78, 1'b0, 4'h0);
    check("final_done", done_o, 1);

    idle_cycle(); idle_cycle();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
